count_history_display: RTL and testbench
========================================

COUNT_HISTORY_DISPLAY -- requirements
Module: count_history_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit stays enabled (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port clear_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port count  input  4  value from the upstream 4-bit counter, sampled every clk.
REQ-005 SHALL have port mode  input  1  display format: 0 = hex glyphs 0-F, 1 = decimal (0-9 glyphs, 10-15 shown as dash).
REQ-006 SHALL have port freeze  input  1  1 = hold history, ignore count changes.
REQ-007 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port an  output  4  active-low digit enables, an[i] selects history slot i.
REQ-009 SHALL have port change_pulse  output  1  one-cycle strobe, high the cycle after a history shift.

Function
REQ-010 SHALL register count into cnt_q on every clk edge, regardless of freeze.
REQ-011 SHALL define change = (count != cnt_q), combinational.
REQ-012 SHALL, on an edge with change=1 and freeze=0, shift history: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=count.
REQ-013 SHALL assert change_pulse for exactly the one cycle after each shift; back-to-back changes give back-to-back pulses.
REQ-014 SHALL, with freeze=1, leave hist unchanged and change_pulse low; changes during freeze are discarded.
REQ-015 SHALL not shift on freeze falling edge unless count differs from cnt_q in that cycle.
REQ-016 SHALL run a prescaler 0..SCAN_DIV-1, wrapping to 0; on the wrap edge digit index idx advances 0->1->2->3->0.
REQ-017 SHALL drive an and seg as registered outputs from the same idx: an = ~(1<<idx), seg = decode(hist[idx], mode); never more than one an bit low.
REQ-018 SHALL decode hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 SHALL, with mode=1 and value 10-15, output dash 0111111.
REQ-020 SHALL apply a mode change to seg at the next clk edge, without resetting scan or history.
REQ-021 SHALL hold each digit enabled for exactly SCAN_DIV cycles, so one full refresh = 4*SCAN_DIV cycles.

Reset
REQ-022 SHALL, on any clk edge with clear_n=0, set cnt_q=0, hist[0..3]=0, prescaler=0, idx=0, change_pulse=0, an=1111, seg=1111111.
REQ-023 SHALL, on the first edge after clear_n rises, drive an=1110 and seg=1000000.
REQ-024 SHALL treat reset mid-scan or mid-shift identically to power-on reset; no shift takes effect on a reset edge.

Structure
REQ-025 SHALL place the digit count (4), the 16 glyph constants and the DASH constant in a shared package.
REQ-026 SHALL use one combinational sub-module, seg7_decoder (inputs value[3:0], mode; output seg[6:0]), instantiated once on the muxed history slot.

Verification
REQ-027 Reset then count 0->1->2->3 on consecutive cycles -> three change_pulses; hist = {3,2,1,0} (slot0..slot3); slot0 shows 0110000.
REQ-028 SCAN_DIV=4, no input change -> an cycles 1110,1101,1011,0111, each held exactly 4 cycles, repeating every 16.
REQ-029 History holds 10 in slot0; toggle mode 0->1 -> slot0 seg changes 0001000 -> 0111111 next edge.
REQ-030 freeze=1 while count steps 5->6->7, then freeze=0 with count stable 7 -> no shift, no change_pulse; count then 7->8 -> one shift, slot0=8.
REQ-031 clear_n=0 for one cycle mid-scan (idx=2) -> next edge an=1111, seg=1111111, hist all 0; edge after release an=1110.
REQ-032 Counter wrap 15->0 in mode=0 -> shift occurs, slot0 shows 1000000, slot1 shows 0001110.

Source files
------------

// File: rtl/count_history_display_pkg.sv
// Shared constants for the count history display: digit count, the
// active-low seven-segment glyphs (bit order {g,f,e,d,c,b,a}) and the
// blank/dash patterns used by the decoder and the top level.
package count_history_display_pkg;

  // Number of history slots, one per display digit
  localparam int NUM_DIGITS = 4;

  // Width of a history slot / counter value
  localparam int VALUE_W = 4;

  // Hexadecimal glyphs 0-F, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Only the middle segment lit: shown for 10-15 in decimal mode
  localparam logic [6:0] DASH = 7'b0111111;

  // All segments dark, driven while the display is held in reset
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All digit enables inactive
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/count_history_display_decoder.sv
// Purely combinational seven-segment decoder. In hex mode every value has
// its own glyph; in decimal mode values above 9 collapse to a dash.
module seg7_decoder
  import count_history_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       mode,
  output logic [6:0] seg
);

  // Select the glyph for the value, then override with a dash for
  // out-of-range decimal digits
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
    if (mode && (value > 4'd9)) begin
      seg = DASH;
    end
  end

endmodule

// File: rtl/count_history_display.sv
// Keeps the last four distinct values seen on an upstream 4-bit counter and
// scans them onto a four-digit multiplexed seven-segment display. Slot 0 is
// the newest value. A freeze input holds the history; changes seen while
// frozen are dropped rather than queued.
module count_history_display
  import count_history_display_pkg::*;
#(
  parameter int SCAN_DIV = 4
)
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic [3:0] count,
  input  logic       mode,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       change_pulse
);

  // Last prescaler value before it wraps; 16 bits covers the full legal range
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [VALUE_W-1:0] cnt_q;
  logic [VALUE_W-1:0] hist [NUM_DIGITS];
  logic [15:0]        prescale;
  logic [1:0]         idx;
  logic               change;
  logic               shift;
  logic [VALUE_W-1:0] shown;
  logic [6:0]         glyph;

  // A shift happens only when the live count differs from last cycle's
  // sample and the history is not frozen
  assign change = (count != cnt_q);
  assign shift  = change & ~freeze;

  // Sample the counter every cycle, even while frozen, so that releasing
  // freeze with a stable count does not look like a change
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= count;
    end
  end

  // History shift register plus the strobe that marks a completed shift
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist[i] <= '0;
      end
      change_pulse <= 1'b0;
    end else begin
      if (shift) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
        end
        hist[0] <= count;
      end
      change_pulse <= shift;
    end
  end

  // Scan timing: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      prescale <= '0;
      idx      <= '0;
    end else if (prescale == SCAN_LAST) begin
      prescale <= '0;
      idx      <= idx + 2'd1;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // Pick the history slot that the current digit index points at
  always_comb begin
    shown = hist[idx];
  end

  seg7_decoder u_decoder (
    .value (shown),
    .mode  (mode),
    .seg   (glyph)
  );

  // Register digit enable and segments together so they always agree on
  // which slot is lit
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= glyph;
    end
  end

endmodule

// File: tb/tb_count_history_display.sv
// Self-checking bench for count_history_display. A behavioural model keeps
// the history as a plain array and derives the lit digit from the number
// of cycles since reset; every cycle the DUT outputs are compared with it.
module tb_count_history_display;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       clear_n;
  logic [3:0] count;
  logic       mode;
  logic       freeze;
  logic [6:0] seg;
  logic [3:0] an;
  logic       change_pulse;

  int testsRun;
  int testsFailed;

  // Reference model state
  int         mEdges;
  logic [3:0] mHist [4];
  logic [3:0] mCnt;
  logic [3:0] expAn;
  logic [6:0] expSeg;
  logic       expPulse;
  int         pulseSeen;

  // Hex glyph table, active-low {g,f,e,d,c,b,a}
  logic [6:0] glyphTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  count_history_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .count        (count),
    .mode         (mode),
    .freeze       (freeze),
    .seg          (seg),
    .an           (an),
    .change_pulse (change_pulse)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] refGlyph(input logic [3:0] v, input logic m);
    if (m && (v > 4'd9)) return 7'b0111111;
    return glyphTab[v];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare all outputs shortly after the edge
  task automatic applyStimulus(input logic [3:0] c, input logic m,
                               input logic f, input logic r);
    int digit;
    count   = c;
    mode    = m;
    freeze  = f;
    clear_n = r;
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 4; k++) mHist[k] = 4'h0;
      mCnt     = 4'h0;
      mEdges   = 0;
      expAn    = 4'b1111;
      expSeg   = 7'b1111111;
      expPulse = 1'b0;
    end else begin
      digit    = (mEdges / SCAN_DIV) % 4;
      expAn    = ~(4'b0001 << digit);
      expSeg   = refGlyph(mHist[digit], m);
      expPulse = (c != mCnt) && !f;
      if (expPulse) begin
        for (int k = 3; k > 0; k--) mHist[k] = mHist[k-1];
        mHist[0] = c;
      end
      mCnt   = c;
      mEdges = mEdges + 1;
    end
    #1;
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("seg", 32'(seg), 32'(expSeg));
    checkOutput("change_pulse", 32'(change_pulse), 32'(expPulse));
    if (change_pulse === 1'b1) pulseSeen++;
  endtask

  // Repeat the current inputs for n cycles
  task automatic holdCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(count, mode, freeze, 1'b1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    pulseSeen   = 0;
    mEdges      = 0;
    mCnt        = 4'h0;
    for (int k = 0; k < 4; k++) mHist[k] = 4'h0;
    count   = 4'h0;
    mode    = 1'b0;
    freeze  = 1'b0;
    clear_n = 1'b0;

    // Reset state
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_an", 32'(an), 32'h0000000F);
    checkOutput("reset_seg", 32'(seg), 32'h0000007F);

    // First edge after release shows slot 0 holding zero
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("release_an", 32'(an), 32'h0000000E);
    checkOutput("release_seg", 32'(seg), 32'h00000040);

    // Count 0->1->2->3 gives three pulses
    pulseSeen = 0;
    applyStimulus(4'h1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h2, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h3, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h3, 1'b0, 1'b0, 1'b1);
    checkOutput("pulse_count", 32'(pulseSeen), 32'd3);

    // Idle scan over two full refresh periods
    holdCycles(8 * SCAN_DIV);

    // Slot 0 holds 10, toggle between hex and decimal while it is shown
    applyStimulus(4'hA, 1'b0, 1'b0, 1'b1);
    holdCycles(4 * SCAN_DIV);
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      applyStimulus(4'hA, (i % 3) == 1, 1'b0, 1'b1);
    end

    // Frozen changes are dropped; release with a stable count is silent
    applyStimulus(4'h5, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h5, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'h6, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'h7, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'h7, 1'b0, 1'b0, 1'b1);
    checkOutput("unfreeze_pulse", 32'(change_pulse), 32'd0);
    applyStimulus(4'h8, 1'b0, 1'b0, 1'b1);
    checkOutput("after_freeze_pulse", 32'(change_pulse), 32'd1);
    holdCycles(4 * SCAN_DIV);

    // Reset in the middle of digit 2
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      if (((mEdges / SCAN_DIV) % 4) == 2 && (mEdges % SCAN_DIV) == 1) break;
      holdCycles(1);
    end
    applyStimulus(count, mode, 1'b0, 1'b0);
    checkOutput("midscan_rst_an", 32'(an), 32'h0000000F);
    checkOutput("midscan_rst_seg", 32'(seg), 32'h0000007F);
    applyStimulus(4'h0, mode, 1'b0, 1'b1);
    checkOutput("midscan_release_an", 32'(an), 32'h0000000E);
    holdCycles(4 * SCAN_DIV);

    // Counter wrap 15 -> 0 in hex mode
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
    holdCycles(8 * SCAN_DIV);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] c;
      logic       m;
      logic       f;
      logic       r;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : count;
      m = ($urandom_range(0, 9) == 0) ? ~mode : mode;
      f = ($urandom_range(0, 7) == 0) ? ~freeze : freeze;
      r = ($urandom_range(0, 59) != 0);
      applyStimulus(c, m, f, r);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
